// File: rtl/input_cond_pkg.sv
// ============================================================================
// Module      : input_cond_pkg
// Description : Shared clog2 helper, default parameter values and counter
//               widths for the input conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package input_cond_pkg;

    // Ceiling log2 with a floor of 1 so that every counter has at least one bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

    localparam int DEF_SAMPLE_COUNT_MAX = 25000;
    localparam int DEF_PULSE_COUNT_MAX  = 200;
    localparam int DEF_LONG_COUNT_MAX   = 2000;
    localparam int DEF_REPEAT_COUNT_MAX = 200;

    localparam int TICK_W = clog2(DEF_SAMPLE_COUNT_MAX);
    localparam int DCNT_W = clog2(DEF_PULSE_COUNT_MAX + 1);
    localparam int HCNT_W = clog2(DEF_LONG_COUNT_MAX + 1);
    localparam int RCNT_W = clog2(DEF_REPEAT_COUNT_MAX + 1);

endpackage

`default_nettype wire

// File: rtl/input_cond_channel.sv
// ============================================================================
// Module      : input_cond_channel
// Description : One conditioned input: synchroniser, symmetric debounce,
//               press/release pulses, long-press and optional auto-repeat
//               (INPUT_COND_AUTOREPEAT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module input_cond_channel
    import input_cond_pkg::*;
#(
    parameter int SYNC_STAGES      = 2,
    parameter int PULSE_COUNT_MAX  = DEF_PULSE_COUNT_MAX,
    parameter int LONG_COUNT_MAX   = DEF_LONG_COUNT_MAX,
`ifdef INPUT_COND_AUTOREPEAT_EN
    parameter int REPEAT_COUNT_MAX = DEF_REPEAT_COUNT_MAX,
`endif
    parameter bit INVERT           = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic pin,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic repeat_pulse
);

    localparam int C_DCNT_W = clog2(PULSE_COUNT_MAX + 1);
    localparam int C_HCNT_W = clog2(LONG_COUNT_MAX + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    logic [C_DCNT_W-1:0]    r_dcnt;
    logic [C_DCNT_W-1:0]    w_dcnt_inc;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;
    logic                   w_flip;
    logic                   w_fall;
    logic [C_HCNT_W-1:0]    r_hcnt;
    logic [C_HCNT_W-1:0]    w_hcnt_inc;
    logic                   w_hold_done;
    logic                   r_long;

    // Inversion happens ahead of the first flop so idle active-low pins read 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pin ^ INVERT};
        end
    end

    assign w_sync     = r_sync[SYNC_STAGES-1];
    assign w_dcnt_inc = r_dcnt + 1'b1;
    assign w_flip     = tick && (w_sync != r_level) &&
                        (w_dcnt_inc == C_DCNT_W'(PULSE_COUNT_MAX));
    assign w_fall     = w_flip && r_level;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dcnt    <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (w_sync == r_level) begin
                r_dcnt <= '0;
            end else if (tick) begin
                if (w_flip) begin
                    r_dcnt    <= '0;
                    r_level   <= ~r_level;
                    r_press   <= ~r_level;
                    r_release <= r_level;
                end else begin
                    r_dcnt <= w_dcnt_inc;
                end
            end
        end
    end

    assign w_hcnt_inc  = r_hcnt + 1'b1;
    assign w_hold_done = (r_hcnt == C_HCNT_W'(LONG_COUNT_MAX));

    // Clearing on the falling tick keeps long_press from landing beside release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hcnt <= '0;
            r_long <= 1'b0;
        end else begin
            r_long <= 1'b0;
            if (!r_level || w_fall) begin
                r_hcnt <= '0;
            end else if (tick && !w_hold_done) begin
                r_hcnt <= w_hcnt_inc;
                r_long <= (w_hcnt_inc == C_HCNT_W'(LONG_COUNT_MAX));
            end
        end
    end

`ifdef INPUT_COND_AUTOREPEAT_EN
    localparam int C_RCNT_W = clog2(REPEAT_COUNT_MAX + 1);

    logic [C_RCNT_W-1:0] r_rcnt;
    logic [C_RCNT_W-1:0] w_rcnt_inc;
    logic                r_repeat;

    assign w_rcnt_inc = r_rcnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rcnt   <= '0;
            r_repeat <= 1'b0;
        end else begin
            r_repeat <= 1'b0;
            if (!r_level || w_fall) begin
                r_rcnt <= '0;
            end else if (tick && w_hold_done) begin
                if (w_rcnt_inc == C_RCNT_W'(REPEAT_COUNT_MAX)) begin
                    r_rcnt   <= '0;
                    r_repeat <= 1'b1;
                end else begin
                    r_rcnt <= w_rcnt_inc;
                end
            end
        end
    end

    assign repeat_pulse = r_repeat;
`else
    assign repeat_pulse = 1'b0;
`endif

    assign level         = r_level;
    assign press         = r_press;
    assign release_pulse = r_release;
    assign long_press    = r_long;

endmodule

`default_nettype wire

// File: rtl/input_conditioner.sv
// ============================================================================
// Module      : input_conditioner
// Description : WIDTH-channel button/switch conditioner with a shared sample
//               tick. Auto-repeat is built when INPUT_COND_AUTOREPEAT_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int               WIDTH            = 4,
    parameter int               SYNC_STAGES      = 2,
    parameter int               SAMPLE_COUNT_MAX = DEF_SAMPLE_COUNT_MAX,
    parameter int               PULSE_COUNT_MAX  = DEF_PULSE_COUNT_MAX,
    parameter int               LONG_COUNT_MAX   = DEF_LONG_COUNT_MAX,
    parameter int               REPEAT_COUNT_MAX = DEF_REPEAT_COUNT_MAX,
    parameter logic [WIDTH-1:0] INVERT           = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] press,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] long_press,
    output logic [WIDTH-1:0] repeat_pulse
);

    localparam int C_TICK_W = clog2(SAMPLE_COUNT_MAX);

    logic [C_TICK_W-1:0] r_tick_cnt;
    logic                w_tick;

    // A single-cycle sample period leaves the counter parked at 0 with tick held high.
    assign w_tick = (r_tick_cnt == C_TICK_W'(SAMPLE_COUNT_MAX - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_channel
        input_cond_channel #(
            .SYNC_STAGES      (SYNC_STAGES),
            .PULSE_COUNT_MAX  (PULSE_COUNT_MAX),
            .LONG_COUNT_MAX   (LONG_COUNT_MAX),
`ifdef INPUT_COND_AUTOREPEAT_EN
            .REPEAT_COUNT_MAX (REPEAT_COUNT_MAX),
`endif
            .INVERT           (INVERT[g])
        ) u_channel (
            .clk           (clk),
            .rst_n         (rst_n),
            .tick          (w_tick),
            .pin           (in[g]),
            .level         (level[g]),
            .press         (press[g]),
            .release_pulse (release_pulse[g]),
            .long_press    (long_press[g]),
            .repeat_pulse  (repeat_pulse[g])
        );
    end

endmodule

`default_nettype wire
